// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package mips_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // Shared with the ALU control decoder.
  localparam logic [1:0] ALU_OP_ADD  = 2'd0;
  localparam logic [1:0] ALU_OP_SUB  = 2'd1;
  localparam logic [1:0] ALU_OP_FUNC = 2'd2;

  localparam logic [1:0] ALUSRCB_RT     = 2'd0;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'd1;
  localparam logic [1:0] ALUSRCB_IMM    = 2'd2;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // States that wait on the memory handshake and are covered by the watchdog.
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wdog.sv
// Memory wait watchdog: counts stalled cycles in a memory state and flags
// expiry when the stall count reaches TIMEOUT with memory still not ready.
module mem_wdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic busy,
  input  logic ready,
  output logic expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    // A restart takes priority so a timed-out FETCH re-enters with a clean count.
    if (start) begin
      cnt_d = '0;
    end else if (busy && !ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expire = busy && !ready && (cnt_q == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute steps and
// drives datapath enables, with a watchdog on memory waits.
module mc_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state_dbg
);

  state_e state_q, state_d;
  logic   wd_start, wd_expire;

  mem_wdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (wd_start),
    .busy   (is_mem_state(state_q)),
    .ready  (mem_ready),
    .expire (wd_expire)
  );

  // Clear on entry to a memory state, including FETCH re-entry after timeout.
  assign wd_start = is_mem_state(state_d) && ((state_d != state_q) || wd_expire);

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUSRCB_RT;
    alu_op        = ALU_OP_ADD;
    pc_source     = PCSRC_ALU;
    illegal_op    = 1'b0;
    mem_err       = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUSRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wd_expire) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = ALUSRCB_IMM_SH;
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUSRCB_IMM;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (wd_expire) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        // The write strobe is withdrawn in the cycle the access is abandoned.
        mem_write = !wd_expire;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (wd_expire) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNC;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_OP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUSRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl with an instruction-sequence reference model
// checked every cycle, plus literal spot checks.
module tb_mc_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       illegal_op, mem_err;
  logic [3:0] state_dbg;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  mc_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal_op    (illegal_op),
    .mem_err       (mem_err),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each instruction is a list of steps; FETCH and DECODE are shared.
  function automatic int seq_at(input logic [5:0] op, input int idx);
    if (idx == 0) return 1;
    if (idx == 1) return 2;
    case (op)
      6'h00: if (idx == 2) return 7;  else if (idx == 3) return 8;
      6'h23: if (idx == 2) return 3;  else if (idx == 3) return 4; else if (idx == 4) return 5;
      6'h2B: if (idx == 2) return 3;  else if (idx == 3) return 6;
      6'h04: if (idx == 2) return 9;
      6'h02: if (idx == 2) return 10;
      6'h08: if (idx == 2) return 11; else if (idx == 3) return 12;
      default: ;
    endcase
    return -1;
  endfunction

  function automatic bit is_mem(input int s);
    return (s == 1) || (s == 4) || (s == 6);
  endfunction

  // Output vector: pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
  // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, src_b[2], alu_op[2], pc_source[2].
  function automatic logic [15:0] exp_vec(input int s, input logic rdy, input bit tmo);
    case (s)
      1:  return rdy ? 16'h9410 : 16'h1010;
      2:  return 16'h0030;
      3:  return 16'h0060;
      4:  return 16'h3000;
      5:  return 16'h0280;
      6:  return tmo ? 16'h2000 : 16'h2800;
      7:  return 16'h0048;
      8:  return 16'h0180;
      9:  return 16'h4045;
      10: return 16'h8002;
      11: return 16'h0060;
      12: return 16'h0080;
      default: return 16'h0000;
    endcase
  endfunction

  int m_st = 0;
  int m_idx = -1;
  int m_wait = 0;

  task automatic m_enter(input int s, input int idx);
    m_st = s;
    m_idx = idx;
    m_wait = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_idx = -1; m_wait = 0;
    end else if (m_st == 0) begin
      m_enter(1, 0);
    end else if (is_mem(m_st) && !mem_ready) begin
      if (m_wait == TIMEOUT) m_enter(1, 0);
      else m_wait++;
    end else begin
      if (seq_at(opcode, m_idx + 1) < 0) m_enter(1, 0);
      else m_enter(seq_at(opcode, m_idx + 1), m_idx + 1);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      bit tmo;
      tmo = is_mem(m_st) && !mem_ready && (m_wait == TIMEOUT);
      chk("state", {28'd0, state_dbg}, m_st);
      chk("outs", {16'd0, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source},
          {16'd0, exp_vec(m_st, mem_ready, tmo)});
      chk("illegal", {31'd0, illegal_op}, {31'd0, (m_st == 2) && (seq_at(opcode, 2) < 0)});
      chk("mem_err", {31'd0, mem_err}, {31'd0, tmo});
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input logic rdy, input logic [5:0] op, input int exp_st);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    opcode = op;
    @(negedge clk);
    #1;
    chk("lit_state", {28'd0, state_dbg}, exp_st);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {28'd0, state_dbg}, 0);
    chk("rst_outs", {16'd0, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                     illegal_op, mem_err}, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("idle_after_rel", {28'd0, state_dbg}, 0);

    // R-type
    tick(1, 6'h00, 1);
    chk("fetch_irw", {30'd0, ir_write, pc_write}, 2'b11);
    chk("fetch_srcb", {30'd0, alu_src_b}, 1);
    tick(1, 6'h00, 2);
    tick(1, 6'h00, 7);
    chk("exec_aluop", {30'd0, alu_op}, 2);
    tick(1, 6'h00, 8);
    chk("aluwb_we", {30'd0, reg_write, reg_dst}, 2'b11);

    // lw with three wait cycles
    tick(1, 6'h23, 1);
    tick(1, 6'h23, 2);
    tick(1, 6'h23, 3);
    tick(0, 6'h23, 4);
    chk("memrd_hold", {30'd0, mem_read, i_or_d}, 2'b11);
    tick(0, 6'h23, 4);
    tick(0, 6'h23, 4);
    tick(1, 6'h23, 4);
    tick(1, 6'h23, 5);
    chk("memwb", {30'd0, reg_write, mem_to_reg}, 2'b11);

    // beq, j
    tick(1, 6'h04, 1);
    tick(1, 6'h04, 2);
    tick(1, 6'h04, 9);
    chk("beq", {29'd0, alu_op, pc_write_cond}, 3'b011);
    tick(1, 6'h02, 1);
    tick(1, 6'h02, 2);
    tick(1, 6'h02, 10);
    chk("jump", {29'd0, pc_source, pc_write}, 3'b101);

    // illegal opcode
    tick(1, 6'h3F, 1);
    tick(1, 6'h3F, 2);
    chk("illegal_pulse", {28'd0, illegal_op, reg_write, mem_write, pc_write}, 4'b1000);
    tick(1, 6'h2B, 1);
    chk("illegal_clear", {31'd0, illegal_op}, 0);

    // sw timeout in MEMWR
    tick(1, 6'h2B, 2);
    tick(1, 6'h2B, 3);
    for (int i = 0; i < 4; i++) tick(0, 6'h2B, 6);
    chk("memwr_no_err", {31'd0, mem_err}, 0);
    tick(0, 6'h2B, 6);
    chk("memwr_tmo", {30'd0, mem_err, mem_write}, 2'b10);
    tick(1, 6'h2B, 1);

    // same, but ready arrives on the timeout cycle
    tick(1, 6'h2B, 2);
    tick(1, 6'h2B, 3);
    for (int i = 0; i < 4; i++) tick(0, 6'h2B, 6);
    tick(1, 6'h2B, 6);
    chk("memwr_ready_wins", {30'd0, mem_err, mem_write}, 2'b01);

    // FETCH timeout then re-entry with cleared counter
    for (int i = 0; i < 4; i++) tick(0, 6'h23, 1);
    tick(0, 6'h23, 1);
    chk("fetch_tmo", {29'd0, mem_err, ir_write, pc_write}, 3'b100);
    tick(0, 6'h23, 1);
    chk("fetch_reenter", {31'd0, mem_err}, 0);
    tick(1, 6'h23, 1);
    tick(1, 6'h23, 2);
    tick(1, 6'h23, 3);
    tick(0, 6'h23, 4);

    // asynchronous reset mid-MEMRD
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {26'd0, state_dbg, mem_read, i_or_d}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // addi
    tick(1, 6'h08, 1);
    tick(1, 6'h08, 2);
    tick(1, 6'h08, 11);
    tick(1, 6'h08, 12);
    chk("addiwb", {29'd0, reg_write, reg_dst, mem_to_reg}, 3'b100);
    tick(1, 6'h00, 1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL time_limit: got timeout want finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle MIPS main control FSM. It drives the `alu_op[1:0]` code into the ALU control decoder and sequences the datapath's register, memory and PC enables.
- It sits between the instruction register's opcode field and the datapath muxes and enables.
- It handles the memory wait handshake and includes a watchdog timeout on memory accesses.

Parameters:
- `TIMEOUT`, default 255: maximum cycles to wait for `mem_ready` in any memory state before aborting. Legal range 1..255.
- `CNT_W`, default 8: width of the wait counter. Must satisfy 2^`CNT_W` > `TIMEOUT`.

Ports:
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `opcode`  in  6: `instr[31:26]` from the instruction register. Sampled in DECODE and in the states after DECODE.
- `mem_ready`  in  1: memory completes the current access this cycle.
- `pc_write`  out  1: unconditional PC load.
- `pc_write_cond`  out  1: PC load if the ALU zero flag is set (beq).
- `i_or_d`  out  1: 0 = instruction address (PC), 1 = data address (ALUOut).
- `mem_read`  out  1: memory read request.
- `mem_write`  out  1: memory write request.
- `ir_write`  out  1: instruction register load enable.
- `mem_to_reg`  out  1: 1 = register write data from MDR.
- `reg_dst`  out  1: 1 = rd, 0 = rt.
- `reg_write`  out  1: register file write enable.
- `alu_src_a`  out  1: 0 = PC, 1 = rs.
- `alu_src_b`  out  2: 0 = rt, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- `alu_op`  out  2: 0 = add, 1 = sub, 2 = decode by function field.
- `pc_source`  out  2: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- `illegal_op`  out  1: one-cycle pulse when an unsupported opcode is decoded.
- `mem_err`  out  1: one-cycle pulse when a memory access times out.
- `state_dbg`  out  4: current state encoding, for the lab display.

Behaviour:
- Reset: the state register goes to IDLE asynchronously and the wait counter clears. In IDLE every output is 0, `state_dbg` is 0 and `alu_op` is 0.
- Outputs are Moore decodes of the state, except the `mem_ready`-gated enables noted below. There are no other combinational input-to-output paths.
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9, JUMP 10, ADDIEX 11, ADDIWB 12.
- IDLE: no outputs asserted. Next state is FETCH.
- FETCH:
  - Asserts `mem_read`, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=0, `pc_source`=0.
  - Asserts `ir_write` and `pc_write` only in the cycle `mem_ready`=1.
  - Stays in FETCH while `mem_ready`=0. Goes to DECODE when `mem_ready`=1.
- DECODE:
  - Asserts `alu_src_a`=0, `alu_src_b`=3, `alu_op`=0 (branch target precompute).
  - Next state by opcode: 0x00 → EXEC; 0x23 and 0x2B → MEMADR; 0x04 → BRANCH; 0x02 → JUMP; 0x08 → ADDIEX.
  - Any other opcode: pulse `illegal_op` and go to FETCH.
- MEMADR: asserts `alu_src_a`=1, `alu_src_b`=2, `alu_op`=0. Next state is MEMRD if opcode is 0x23, otherwise MEMWR.
- MEMRD: asserts `mem_read` and `i_or_d`=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: asserts `reg_write`, `mem_to_reg`=1, `reg_dst`=0. Next state is FETCH.
- MEMWR:
  - Asserts `mem_write` and `i_or_d`=1, held stable until `mem_ready`=1.
  - Goes to FETCH when `mem_ready`=1.
- EXEC: asserts `alu_src_a`=1, `alu_src_b`=0, `alu_op`=2. Next state is ALUWB.
- ALUWB: asserts `reg_write`, `reg_dst`=1, `mem_to_reg`=0. Next state is FETCH.
- BRANCH: asserts `alu_src_a`=1, `alu_src_b`=0, `alu_op`=1, `pc_write_cond`, `pc_source`=1. Next state is FETCH.
- JUMP: asserts `pc_write` and `pc_source`=2. Next state is FETCH.
- ADDIEX: asserts `alu_src_a`=1, `alu_src_b`=2, `alu_op`=0. Next state is ADDIWB.
- ADDIWB: asserts `reg_write`, `reg_dst`=0, `mem_to_reg`=0. Next state is FETCH.
- Cycle counts, with zero-wait memory:
  - lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Each memory wait cycle adds 1.
- Watchdog:
  - The counter clears on entry to FETCH, MEMRD or MEMWR, and increments on each cycle in those states with `mem_ready`=0.
  - When `mem_ready`=0 and the count equals `TIMEOUT`: pulse `mem_err`, go to FETCH, and assert no writes in that cycle.
  - If `mem_ready` and the timeout coincide, `mem_ready` wins and there is no error.
  - After a FETCH timeout, FETCH re-enters with the counter cleared. The PC is not advanced.
- Reset mid-operation: any state goes to IDLE immediately. In-flight memory requests drop the same cycle.
- `illegal_op` and `mem_err` are never asserted together.

Decomposition:
- Shared package `mips_pkg` holds:
  - the state enum and its encodings;
  - opcode constants `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`, `OP_ADDI`;
  - `ALU_OP_ADD`/`SUB`/`FUNC` (0/1/2);
  - `ALUSRCB_*` and `PCSRC_*` encodings.
- The `alu_op` values are shared with the ALU control decoder.
- One sub-module, `mem_wdog`: the wait counter and timeout compare, with inputs `start`, `busy`, `ready` and output `expire`.
- The FSM and output decode stay in `mc_ctrl`.

Test Plan:
- Reset, then release `rst_n` with `mem_ready`=1 → IDLE with all outputs 0. Next cycle FETCH with `ir_write`=`pc_write`=1 and `alu_src_b`=1.
- opcode 0x00, `mem_ready`=1 → states 1, 2, 7, 8, 1. `alu_op`=2 in EXEC. `reg_write`=1 and `reg_dst`=1 in ALUWB.
- opcode 0x23, `mem_ready` low 3 cycles in MEMRD → states 1, 2, 3, 4, 4, 4, 4, 5, 1. `mem_read` and `i_or_d`=1 held. `reg_write` and `mem_to_reg`=1 in MEMWB.
- opcode 0x04 then 0x02 → BRANCH with `alu_op`=1 and `pc_write_cond`=1. JUMP with `pc_source`=2 and `pc_write`=1. Each completes in 3 cycles.
- opcode 0x3F → `illegal_op` pulses once in DECODE, next state FETCH, no write enables asserted.
- `TIMEOUT`=4, `mem_ready` held 0 in MEMWR → `mem_err` pulses on the 5th MEMWR cycle, then FETCH. Repeat with `mem_ready`=1 on that same cycle → no `mem_err`. Assert `rst_n`=0 mid-MEMRD → IDLE asynchronously.
